// File: rtl/trap_sequencer.sv
// rtl/trap_sequencer.sv - trap entry / MRET sequencer driving pipeline stall, flush and PC select
module trap_sequencer #(
  parameter int XLEN         = 32,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            irq_pending,
  input  logic            is_mret_E,
  input  logic            stall_haz,
  input  logic            br_taken,
  input  logic [XLEN-1:0] pc_D,
  output logic            stall_F,
  output logic            stall_D,
  output logic            flush_D,
  output logic            flush_E,
  output logic [1:0]      pc_sel,
  output logic            epc_wr,
  output logic [XLEN-1:0] epc_val,
  output logic            mret_ack,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    TAKE  = 2'd2,
    RET   = 2'd3
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(DRAIN_CYCLES - 1);

  localparam logic [1:0] PC_SEQ   = 2'b00;
  localparam logic [1:0] PC_TRAP  = 2'b01;
  localparam logic [1:0] PC_MEPC  = 2'b10;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  // State and drain counter registers; reset always returns to IDLE with an empty counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: MRET wins over interrupts, taken branches defer trap entry by a cycle
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (is_mret_E) begin
          state_nxt = RET;
        end else if (irq_pending && !br_taken) begin
          state_nxt = DRAIN;
          cnt_nxt   = CNT_INIT;
        end
      end
      DRAIN: begin
        cnt_nxt = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
        if (!irq_pending) begin
          state_nxt = IDLE;
        end else if (cnt == 4'd0 && !stall_haz) begin
          state_nxt = TAKE;
        end
      end
      TAKE:    state_nxt = IDLE;
      RET:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from current state and inputs; everything is forced low while in reset
  always_comb begin
    stall_F  = 1'b0;
    stall_D  = 1'b0;
    flush_D  = 1'b0;
    flush_E  = 1'b0;
    pc_sel   = PC_SEQ;
    epc_wr   = 1'b0;
    epc_val  = '0;
    mret_ack = 1'b0;
    busy     = 1'b0;
    if (!rst) begin
      busy = (state != IDLE);
      case (state)
        IDLE: begin
          stall_F = stall_haz;
          stall_D = stall_haz;
          flush_E = stall_haz;
          flush_D = br_taken;
        end
        DRAIN: begin
          stall_F = 1'b1;
          stall_D = 1'b1;
          flush_E = 1'b1;
          flush_D = br_taken;
        end
        TAKE: begin
          pc_sel  = PC_TRAP;
          epc_wr  = 1'b1;
          epc_val = pc_D;
          flush_D = 1'b1;
          flush_E = 1'b1;
        end
        RET: begin
          pc_sel   = PC_MEPC;
          mret_ack = 1'b1;
          flush_D  = 1'b1;
          flush_E  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// tb/tb_trap_sequencer.sv - scoreboard bench for trap_sequencer
module tb_trap_sequencer;

  localparam int XLEN = 32;
  localparam int DC   = 2;

  logic            clk = 1'b0;
  logic            rst, irq_pending, is_mret_E, stall_haz, br_taken;
  logic [XLEN-1:0] pc_D;
  logic            stall_F, stall_D, flush_D, flush_E, epc_wr, mret_ack, busy;
  logic [1:0]      pc_sel;
  logic [XLEN-1:0] epc_val;

  trap_sequencer #(.XLEN(XLEN), .DRAIN_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .irq_pending(irq_pending), .is_mret_E(is_mret_E),
    .stall_haz(stall_haz), .br_taken(br_taken), .pc_D(pc_D),
    .stall_F(stall_F), .stall_D(stall_D), .flush_D(flush_D), .flush_E(flush_E),
    .pc_sel(pc_sel), .epc_wr(epc_wr), .epc_val(epc_val), .mret_ack(mret_ack),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            sf, sd, fd, fe;
    logic [1:0]      ps;
    logic            ew;
    logic [XLEN-1:0] ev;
    logic            ma, bz;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   epc_cnt = 0;

  // reference model state: 0 idle, 1 drain, 2 take, 3 ret
  int   m_state = 0;
  int   m_cnt   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e = '0;
    if (!rst) begin
      e.bz = (m_state != 0);
      case (m_state)
        0: begin e.sf = stall_haz; e.sd = stall_haz; e.fe = stall_haz; e.fd = br_taken; end
        1: begin e.sf = 1; e.sd = 1; e.fe = 1; e.fd = br_taken; end
        2: begin e.ps = 2'b01; e.ew = 1; e.ev = pc_D; e.fd = 1; e.fe = 1; end
        default: begin e.ps = 2'b10; e.ma = 1; e.fd = 1; e.fe = 1; end
      endcase
    end
    return e;
  endfunction

  task automatic model_step();
    if (rst) begin
      m_state = 0; m_cnt = 0;
    end else begin
      case (m_state)
        0: if (is_mret_E) m_state = 3;
           else if (irq_pending && !br_taken) begin m_state = 1; m_cnt = DC - 1; end
        1: begin
             int c0 = m_cnt;
             if (m_cnt > 0) m_cnt--;
             if (!irq_pending) m_state = 0;
             else if (c0 == 0 && !stall_haz) m_state = 2;
           end
        default: m_state = 0;
      endcase
    end
  endtask

  // one clock: drive, push expectation, compare at negedge, advance model at posedge
  task automatic cyc(input logic r, input logic irq, input logic mr, input logic sh,
                     input logic br, input logic [XLEN-1:0] pc);
    exp_t e;
    rst = r; irq_pending = irq; is_mret_E = mr; stall_haz = sh; br_taken = br; pc_D = pc;
    sb.push_back(model_out());
    @(negedge clk);
    if (sb.size() == 0) begin
      check("sb_empty", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check("stall_F",  64'(stall_F),  64'(e.sf));
      check("stall_D",  64'(stall_D),  64'(e.sd));
      check("flush_D",  64'(flush_D),  64'(e.fd));
      check("flush_E",  64'(flush_E),  64'(e.fe));
      check("pc_sel",   64'(pc_sel),   64'(e.ps));
      check("epc_wr",   64'(epc_wr),   64'(e.ew));
      check("epc_val",  64'(epc_val),  64'(e.ev));
      check("mret_ack", 64'(mret_ack), 64'(e.ma));
      check("busy",     64'(busy),     64'(e.bz));
    end
    if (epc_wr) epc_cnt++;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 32'h0);
  endtask

  initial begin
    rst = 1; irq_pending = 0; is_mret_E = 0; stall_haz = 0; br_taken = 0; pc_D = '0;
    @(posedge clk); #1;

    // reset holds all outputs low regardless of inputs
    cyc(1, 1, 1, 1, 1, 32'hFFFF_FFFF);
    cyc(1, 1, 0, 1, 1, 32'h1234_5678);
    idle_n(2);

    // basic trap entry: DRAIN x2, TAKE with epc=0x40, back to IDLE
    epc_cnt = 0;
    cyc(0, 1, 0, 0, 0, 32'h40);
    cyc(0, 1, 0, 0, 0, 32'h40);
    cyc(0, 1, 0, 0, 0, 32'h40);
    check("take_strobe", 64'(epc_cnt), 64'd0);
    cyc(0, 1, 0, 0, 0, 32'h40);
    check("take_once", 64'(epc_cnt), 64'd1);
    cyc(0, 0, 0, 0, 0, 32'h44);
    idle_n(2);

    // MRET beats a simultaneous interrupt
    epc_cnt = 0;
    cyc(0, 1, 1, 0, 0, 32'h80);
    cyc(0, 1, 0, 0, 0, 32'h80);
    check("mret_no_epc", 64'(epc_cnt), 64'd0);
    cyc(0, 0, 0, 0, 0, 32'h80);
    idle_n(2);

    // hazard stall holds DRAIN; exactly one TAKE afterwards
    epc_cnt = 0;
    cyc(0, 1, 0, 1, 0, 32'h100);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 1, 0, 32'h100);
    check("haz_hold", 64'(epc_cnt), 64'd0);
    cyc(0, 1, 0, 0, 0, 32'h100);
    cyc(0, 1, 0, 0, 0, 32'h100);
    cyc(0, 0, 0, 0, 0, 32'h104);
    idle_n(3);
    check("haz_take_once", 64'(epc_cnt), 64'd1);

    // interrupt withdrawn during DRAIN
    epc_cnt = 0;
    cyc(0, 1, 0, 0, 0, 32'h200);
    cyc(0, 0, 0, 0, 0, 32'h200);
    idle_n(3);
    check("drop_no_epc", 64'(epc_cnt), 64'd0);

    // reset asserted in TAKE: no second strobe
    epc_cnt = 0;
    cyc(0, 1, 0, 0, 0, 32'h300);
    cyc(0, 1, 0, 0, 0, 32'h300);
    cyc(0, 1, 0, 0, 0, 32'h300);
    cyc(1, 1, 0, 0, 0, 32'h300);
    cyc(0, 0, 0, 0, 0, 32'h300);
    idle_n(2);
    check("rst_take_no_epc", 64'(epc_cnt), 64'd0);

    // taken branch defers entry one cycle; branch in DRAIN only flushes Decode
    cyc(0, 1, 0, 0, 1, 32'h400);
    cyc(0, 1, 0, 0, 0, 32'h400);
    cyc(0, 1, 0, 0, 1, 32'h400);
    cyc(0, 1, 0, 0, 1, 32'h400);
    cyc(0, 0, 0, 0, 0, 32'h404);
    idle_n(2);

    // random traffic against the model
    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(0, 31) == 0), ($urandom_range(0, 2) != 0), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), $urandom);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
